i2s_sample_tx: RTL and testbench

Output stage directly downstream of the overdrive clamp. It accepts signed fixed-point samples on a valid/ready handshake, scales and saturates each one to 24-bit PCM, and buffers them in a small FIFO. It then serialises every sample as a mono I2S frame (same word on left and right) to the external DAC, generating BCLK and LRCLK from the system clock.

---
 rtl/i2s_sample_tx_pkg.sv | 34 +++
 rtl/i2s_sample_tx_fifo.sv | 71 +++++++
 rtl/i2s_sample_tx.sv | 159 +++++++++++++++
 tb/tb_i2s_sample_tx.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_sample_tx_pkg.sv
// Shared types, frame constants and the fixed-point to PCM conversion
// used by the I2S sample transmitter.
package i2s_tx_pkg;

   localparam int FRAME_BITS    = 64;
   localparam int SLOT_BITS     = 32;
   localparam int DAC_WIDTH_DEF = 24;

   typedef logic signed [DAC_WIDTH_DEF-1:0] pcm_t;

   typedef enum logic {
      ST_WAIT = 1'b0,
      ST_RUN  = 1'b1
   } tx_state_e;

   // Aligns a fixed-point sample with bpl fractional bits to a w-bit PCM word
   // and clamps it, since upstream can overshoot full scale slightly.
   function automatic logic signed [63:0] scale_sat(input int x, input int bpl, input int w);
      logic signed [63:0] v;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      v  = 64'(x) <<< (w - 1 - bpl);
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) begin
         return hi;
      end
      if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/i2s_sample_tx_fifo.sv
// Small synchronous FIFO with asynchronous reset; read data is the
// head entry, presented combinationally.
module sample_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (level_q == (AW+1)'(DEPTH));
   assign empty   = (level_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_data = mem_q[rd_ptr_q];
   assign level   = level_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   // Storage needs no reset: the pointers and level define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/i2s_sample_tx.sv
// Scales samples to PCM, buffers them and sends each as a mono I2S frame.
// Build option I2S_TX_UNDERRUN_ZERO_EN: send silence instead of repeating on underrun.
module i2s_sample_tx
   import i2s_tx_pkg::*;
#(
   parameter int BITS_PER_LEVEL = 12,
   parameter int DAC_WIDTH      = 24,
   parameter int BCLK_DIV       = 4,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [31:0]                   in_sample,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          bclk,
   output logic                          lrclk,
   output logic                          sdata,
   output logic                          underrun,
   output logic [15:0]                   underrun_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int IW    = $clog2(DAC_WIDTH);

   tx_state_e            state_q, state_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic                 bclk_q, bclk_d;
   logic                 lrclk_q, lrclk_d;
   logic                 sdata_q, sdata_d;
   logic                 underrun_q, underrun_d;
   logic [15:0]          ucnt_q, ucnt_d;
   logic [5:0]           bit_cnt_q, bit_cnt_d;
   logic [DAC_WIDTH-1:0] held_q, held_d;

   logic [DAC_WIDTH-1:0] pcm_in;
   logic [DAC_WIDTH-1:0] fifo_rd;
   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 bclk_fall;
   int                   slot_pos;
   logic [IW-1:0]        bit_idx;

   assign pcm_in    = DAC_WIDTH'(scale_sat(int'(signed'(in_sample)), BITS_PER_LEVEL, DAC_WIDTH));
   // No full-bypass: a pop in the same cycle does not open the input.
   assign in_ready  = ~fifo_full;
   assign fifo_push = in_valid & ~fifo_full;

   sample_fifo #(
      .WIDTH (DAC_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (fifo_push),
      .wr_data (pcm_in),
      .pop     (fifo_pop),
      .rd_data (fifo_rd),
      .level   (fifo_level),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bclk_d     = bclk_q;
      lrclk_d    = lrclk_q;
      sdata_d    = sdata_q;
      underrun_d = 1'b0;
      ucnt_d     = ucnt_q;
      bit_cnt_d  = bit_cnt_q;
      held_d     = held_q;
      fifo_pop   = 1'b0;
      bclk_fall  = 1'b0;
      slot_pos   = 0;
      bit_idx    = '0;
      case (state_q)
         ST_WAIT: begin
            if (fifo_level != '0) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (div_q == DIV_W'(BCLK_DIV - 1)) begin
               div_d     = '0;
               bclk_d    = ~bclk_q;
               bclk_fall = bclk_q;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
            // Everything on the serial side moves together with the falling bclk.
            if (bclk_fall) begin
               bit_cnt_d = bit_cnt_q + 6'd1;
               if (bit_cnt_d == 6'd0) begin
                  lrclk_d = 1'b0;
                  if (!fifo_empty) begin
                     fifo_pop = 1'b1;
                     held_d   = fifo_rd;
                  end else begin
                     underrun_d = 1'b1;
                     if (ucnt_q != 16'hFFFF) begin
                        ucnt_d = ucnt_q + 16'd1;
                     end
`ifdef I2S_TX_UNDERRUN_ZERO_EN
                     held_d = '0;
`endif
                  end
               end else if (bit_cnt_d == 6'd32) begin
                  lrclk_d = 1'b1;
               end
               // Slot bit 0 is the I2S one-bclk delay; the MSB follows it.
               slot_pos = int'(bit_cnt_d[4:0]);
               if (slot_pos >= 1 && slot_pos <= DAC_WIDTH) begin
                  bit_idx = IW'(DAC_WIDTH - slot_pos);
                  sdata_d = held_q[bit_idx];
               end else begin
                  sdata_d = 1'b0;
               end
            end
         end
         default: state_d = ST_WAIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_WAIT;
         div_q      <= '0;
         bclk_q     <= 1'b0;
         lrclk_q    <= 1'b1;
         sdata_q    <= 1'b0;
         underrun_q <= 1'b0;
         ucnt_q     <= '0;
         bit_cnt_q  <= 6'd63;
         held_q     <= '0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bclk_q     <= bclk_d;
         lrclk_q    <= lrclk_d;
         sdata_q    <= sdata_d;
         underrun_q <= underrun_d;
         ucnt_q     <= ucnt_d;
         bit_cnt_q  <= bit_cnt_d;
         held_q     <= held_d;
      end
   end

   assign bclk         = bclk_q;
   assign lrclk        = lrclk_q;
   assign sdata        = sdata_q;
   assign underrun     = underrun_q;
   assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Directed bench for i2s_sample_tx: conversion, FIFO fill, underrun,
// mid-frame reset and bit/frame clock periods at two BCLK dividers.
`timescale 1ns/1ps
module tb_i2s_sample_tx;

   logic        clk;
   logic        rst;
   logic [31:0] in_sample;
   logic        in_valid;
   logic        in_ready;
   logic        bclk;
   logic        lrclk;
   logic        sdata;
   logic        underrun;
   logic [15:0] underrun_cnt;
   logic [2:0]  fifo_level;

   logic [31:0] in_sample_2;
   logic        in_valid_2;
   logic        in_ready_2;
   logic        bclk_2;
   logic        lrclk_2;
   logic        sdata_2;
   logic        underrun_2;
   logic [15:0] underrun_cnt_2;
   logic [2:0]  fifo_level_2;

   int vectors;
   int miscompares;
   int rd_idx;

`ifdef I2S_TX_UNDERRUN_ZERO_EN
   localparam logic [23:0] REPEAT_M1   = 24'h000000;
   localparam logic [23:0] REPEAT_1000 = 24'h000000;
`else
   localparam logic [23:0] REPEAT_M1   = 24'hFFF800;
   localparam logic [23:0] REPEAT_1000 = 24'h1F4000;
`endif

   i2s_sample_tx dut (
      .clk          (clk),
      .rst          (rst),
      .in_sample    (in_sample),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .bclk         (bclk),
      .lrclk        (lrclk),
      .sdata        (sdata),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt),
      .fifo_level   (fifo_level)
   );

   i2s_sample_tx #(.BCLK_DIV(1)) dut_div1 (
      .clk          (clk),
      .rst          (rst),
      .in_sample    (in_sample_2),
      .in_valid     (in_valid_2),
      .in_ready     (in_ready_2),
      .bclk         (bclk_2),
      .lrclk        (lrclk_2),
      .sdata        (sdata_2),
      .underrun     (underrun_2),
      .underrun_cnt (underrun_cnt_2),
      .fifo_level   (fifo_level_2)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- frame monitor (captures on bclk rising, sampled at negedge) ----------------
   logic [63:0] got_bits[$];
   logic [63:0] got_lr[$];
   logic [63:0] cap_bits;
   logic [63:0] cap_lr;
   int          cap_n;
   logic        prev_b;
   logic        prev_lr;

   initial begin
      cap_n   = -1;
      prev_b  = 1'b0;
      prev_lr = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            cap_n   = -1;
            prev_b  = 1'b0;
            prev_lr = 1'b1;
         end else begin
            if (prev_lr && !lrclk) begin
               cap_n = 0;
            end
            if (!prev_b && bclk && cap_n >= 0) begin
               cap_bits = {sdata, cap_bits[63:1]};
               cap_lr   = {lrclk, cap_lr[63:1]};
               cap_n++;
               if (cap_n == 64) begin
                  got_bits.push_back(cap_bits);
                  got_lr.push_back(cap_lr);
                  cap_n = -1;
               end
            end
            prev_b  = bclk;
            prev_lr = lrclk;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] v);
      in_sample = v;
      in_valid  = 1'b1;
      step();
      in_valid  = 1'b0;
   endtask

   // Expected serial pattern: bit k of the frame, slot position p = k mod 32
   function automatic logic [63:0] frame_pattern(input logic [23:0] w);
      logic [63:0] b;
      int p;
      b = '0;
      for (int k = 0; k < 64; k++) begin
         p = k % 32;
         if (p >= 1 && p <= 24) begin
            b[k] = w[24 - p];
         end
      end
      return b;
   endfunction

   task automatic check_frame(input logic [23:0] w, input string tag);
      int t;
      t = 0;
      while (got_bits.size() <= rd_idx && t < 2000) begin
         step();
         t++;
      end
      if (got_bits.size() <= rd_idx) begin
         chk({tag, "_timeout"}, 64'(got_bits.size()), 64'(rd_idx + 1));
      end else begin
         chk({tag, "_bits"}, got_bits[rd_idx], frame_pattern(w));
         chk({tag, "_lr"}, got_lr[rd_idx], 64'hFFFFFFFF_00000000);
         rd_idx++;
      end
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0:       return bclk;
         1:       return lrclk;
         2:       return bclk_2;
         3:       return lrclk_2;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_edge(input int sel, input bit rising, output int cycles);
      logic prev;
      logic cur;
      int   n;
      prev   = sig(sel);
      n      = 0;
      cycles = -1;
      while (n < 1200) begin
         step();
         n++;
         cur = sig(sel);
         if (rising ? (!prev && cur) : (prev && !cur)) begin
            cycles = n;
            break;
         end
         prev = cur;
      end
   endtask

   task automatic wait_underrun(input string tag);
      int n;
      n = 0;
      while (underrun !== 1'b1 && n < 1200) begin
         step();
         n++;
      end
      chk({tag, "_pulse"}, 64'(underrun), 64'd1);
      chk({tag, "_cnt"}, 64'(underrun_cnt), 64'd1);
      chk({tag, "_lr"}, 64'(lrclk), 64'd0);
      step();
      chk({tag, "_width"}, 64'(underrun), 64'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int  c;
      int  n;
      logic hold;
      vectors     = 0;
      miscompares = 0;
      rd_idx      = 0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_sample   = '0;
      in_valid_2  = 1'b0;
      in_sample_2 = '0;
      repeat (3) step();

      chk("rst_bclk", 64'(bclk), 64'd0);
      chk("rst_lrclk", 64'(lrclk), 64'd1);
      chk("rst_sdata", 64'(sdata), 64'd0);
      chk("rst_underrun", 64'(underrun), 64'd0);
      chk("rst_ucnt", 64'(underrun_cnt), 64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;
      repeat (2) step();

      // fill the FIFO, then hold a fifth sample against a full FIFO
      push(32'd2048);
      push(32'd4096);
      push(32'd5000);
      push(-32'sd4096);
      chk("fill_level", 64'(fifo_level), 64'd4);
      chk("fill_ready", 64'(in_ready), 64'd0);
      in_sample = 32'hFFFF_FFFF;
      in_valid  = 1'b1;
      n = 0;
      while (fifo_level == 3'd4 && n < 600) begin
         step();
         n++;
      end
      chk("pop_level", 64'(fifo_level), 64'd3);
      chk("pop_ready", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      chk("refill_level", 64'(fifo_level), 64'd4);

      check_frame(24'h400000, "f_2048");
      check_frame(24'h7FFFFF, "f_4096");
      check_frame(24'h7FFFFF, "f_5000");
      check_frame(24'h800000, "f_m4096");
      check_frame(24'hFFF800, "f_m1");
      wait_underrun("ur_a");
      check_frame(REPEAT_M1, "f_m1_again");

      // reset while bclk is high at bit 40 of the right slot
      wait_edge(1, 1'b1, c);
      push(32'd1000);
      chk("mid_level", 64'(fifo_level), 64'd1);
      repeat (8) wait_edge(0, 1'b0, c);
      wait_edge(0, 1'b1, c);
      chk("mid_bclk_hi", 64'(bclk), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("mr_bclk", 64'(bclk), 64'd0);
      chk("mr_lrclk", 64'(lrclk), 64'd1);
      chk("mr_sdata", 64'(sdata), 64'd0);
      chk("mr_level", 64'(fifo_level), 64'd0);
      chk("mr_ready", 64'(in_ready), 64'd1);
      chk("mr_ucnt", 64'(underrun_cnt), 64'd0);
      #4 rst = 1'b0;
      rd_idx = got_bits.size();
      hold = 1'b1;
      repeat (20) begin
         step();
         if (bclk !== 1'b0 || lrclk !== 1'b1 || sdata !== 1'b0 || fifo_level !== 3'd0) hold = 1'b0;
      end
      chk("wait_hold", 64'(hold), 64'd1);

      // single sample, then starve
      push(32'd1000);
      check_frame(24'h1F4000, "f_1000");
      wait_underrun("ur_b");
      check_frame(REPEAT_1000, "f_1000_again");

      // clock periods at BCLK_DIV=4
      wait_edge(0, 1'b1, c);
      wait_edge(0, 1'b1, c);
      chk("bclk_period_div4", 64'(c), 64'd8);
      wait_edge(1, 1'b0, c);
      wait_edge(1, 1'b0, c);
      chk("frame_period_div4", 64'(c), 64'd512);

      // clock periods at BCLK_DIV=1
      in_sample_2 = 32'd1000;
      in_valid_2  = 1'b1;
      step();
      in_valid_2  = 1'b0;
      wait_edge(2, 1'b1, c);
      wait_edge(2, 1'b1, c);
      chk("bclk_period_div1", 64'(c), 64'd2);
      wait_edge(3, 1'b0, c);
      wait_edge(3, 1'b0, c);
      chk("frame_period_div1", 64'(c), 64'd128);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
